gcd_arbiter: RTL and testbench

//  Shares one GCD datapath core (go/x/y in, done/result out) among N requesters.

---
 rtl/gcd_arbiter.sv | 143 ++++++++++++++
 tb/tb_gcd_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one GCD core among N requesters.
// Handles operand capture, core sequencing, zero-operand bypass and a hung-core watchdog.
module gcd_arbiter #(
    parameter int N       = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_i,
    input  logic [N*W-1:0] x_i,
    input  logic [N*W-1:0] y_i,
    output logic [N-1:0]   gnt_o,
    output logic [N-1:0]   ack_o,
    output logic [W-1:0]   d_o,
    output logic           err_o,
    output logic           busy_o,
    output logic           core_go_o,
    output logic [W-1:0]   core_x_o,
    output logic [W-1:0]   core_y_o,
    input  logic           core_done_i,
    input  logic [W-1:0]   core_d_i,
    output logic           core_rst_o
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, win;
    logic [W-1:0]  x_q, x_d, y_q, y_d, res_q, res_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          found;
    logic          zero_op;
    int            cand;

    assign zero_op = (x_q == '0) || (y_q == '0);

    // First requester at or after ptr, wrapping
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr_q) + i) % N;
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = IW'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = win;
                    x_d     = x_i[int'(win)*W +: W];
                    y_d     = y_i[int'(win)*W +: W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (zero_op) begin
                    // gcd(0,v) = v, and gcd(0,0) = 0 falls out of the same OR
                    res_d   = x_q | y_q;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (core_done_i) begin
                    res_d   = core_d_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // res_q only changes on entry to RESP, so d_o holds between acks
    always_comb begin
        gnt_o = '0;
        ack_o = '0;
        if (state_q == ISSUE) gnt_o[idx_q] = 1'b1;
        if (state_q == RESP)  ack_o[idx_q] = 1'b1;
    end

    assign d_o        = res_q;
    assign err_o      = (state_q == RESP) && err_q;
    assign core_rst_o = (state_q == RESP) && err_q;
    assign busy_o     = (state_q != IDLE);
    assign core_go_o  = (state_q == ISSUE) && !zero_op;
    assign core_x_o   = x_q;
    assign core_y_o   = y_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter with a behavioural GCD core model.
`timescale 1ns/1ps
module tb_gcd_arbiter;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int TO = 64;

    typedef struct {
        int           slot;
        logic [W-1:0] d;
        logic         err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] x = '0, y = '0;
    logic [N-1:0]   gnt_o, ack_o;
    logic [W-1:0]   d_o, core_x_o, core_y_o, core_d_i;
    logic           err_o, busy_o, core_go_o, core_done_i, core_rst_o;

    int   checks = 0, failures = 0;
    int   gq[$];
    exp_t aq[$];
    int   go_cnt = 0;
    time  t0;

    gcd_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req), .x_i(x), .y_i(y),
        .gnt_o(gnt_o), .ack_o(ack_o), .d_o(d_o), .err_o(err_o), .busy_o(busy_o),
        .core_go_o(core_go_o), .core_x_o(core_x_o), .core_y_o(core_y_o),
        .core_done_i(core_done_i), .core_d_i(core_d_i), .core_rst_o(core_rst_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] t;
        while (b != 0) begin
            t = b;
            b = a % b;
            a = t;
        end
        return a;
    endfunction

    // Core model: done for one cycle, core_lat cycles after go (1 = first WAIT cycle)
    int           core_lat = 1;
    bit           core_hang = 1'b0;
    bit           done_force = 1'b0;
    logic         cm_act;
    int           cm_cnt;
    logic [W-1:0] cm_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cm_act <= 1'b0; cm_cnt <= 0; cm_res <= '0;
        end else if (core_rst_o) begin
            cm_act <= 1'b0;
        end else if (core_go_o) begin
            cm_act <= 1'b1;
            cm_cnt <= core_lat - 1;
            cm_res <= gcd_ref(core_x_o, core_y_o);
        end else if (cm_act) begin
            if (cm_cnt == 0) cm_act <= 1'b0;
            else             cm_cnt <= cm_cnt - 1;
        end
    end
    assign core_done_i = (cm_act && cm_cnt == 0 && !core_hang) || done_force;
    assign core_d_i    = cm_res;

    // Scoreboard monitor: grants and acks are checked against the queues in order
    logic [N-1:0] ev;
    exp_t         me;
    logic         p_gnt, p_ack, p_go, p_rst;
    always @(negedge clk) begin
        if (rst) begin
            p_gnt = 0; p_ack = 0; p_go = 0; p_rst = 0;
        end else begin
            if (gnt_o != 0) begin
                checks++;
                if (gq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_gnt: got %b required none", gnt_o);
                end else begin
                    ev = '0; ev[gq.pop_front()] = 1'b1;
                    if (gnt_o !== ev) begin
                        failures++;
                        $display("FAIL gnt_order: got %b required %b", gnt_o, ev);
                    end
                end
            end
            if (ack_o != 0) begin
                checks++;
                if (aq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack: got %b required none", ack_o);
                end else begin
                    me = aq.pop_front();
                    ev = '0; ev[me.slot] = 1'b1;
                    if ({ack_o, d_o, err_o, core_rst_o} !== {ev, me.d, me.err, me.err}) begin
                        failures++;
                        $display("FAIL ack_result: got ack=%b d=%0d err=%b crst=%b required ack=%b d=%0d err=%b crst=%b",
                                 ack_o, d_o, err_o, core_rst_o, ev, me.d, me.err, me.err);
                    end
                end
            end
            if (p_gnt) begin checks++; if (gnt_o !== '0) begin failures++; $display("FAIL gnt_pulse: got %b required 0", gnt_o); end end
            if (p_ack) begin checks++; if (ack_o !== '0) begin failures++; $display("FAIL ack_pulse: got %b required 0", ack_o); end end
            if (p_go)  begin checks++; if (core_go_o !== 1'b0) begin failures++; $display("FAIL go_pulse: got 1 required 0"); end end
            if (p_rst) begin checks++; if (core_rst_o !== 1'b0) begin failures++; $display("FAIL crst_pulse: got 1 required 0"); end end
            p_gnt = (gnt_o != 0); p_ack = (ack_o != 0); p_go = core_go_o; p_rst = core_rst_o;
            if (core_go_o) go_cnt++;
        end
    end

    task automatic set_ops(input int k, input logic [W-1:0] xv, input logic [W-1:0] yv);
        x[k*W +: W] = xv;
        y[k*W +: W] = yv;
    endtask

    task automatic expect_txn(input int k, input logic [W-1:0] d, input logic err);
        exp_t e;
        e.slot = k; e.d = d; e.err = err;
        gq.push_back(k);
        aq.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Returns the cycle number (cycle 1 = the one right after edge t0) of the next ack, or -1
    task automatic wait_ack(input int maxc, output int kc);
        kc = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (ack_o != 0) begin
                kc = int'(($time - t0 - 5) / 10) + 1;
                break;
            end
        end
    endtask

    // Requesters drop req on their own grant; ends when everything is served
    task automatic run_until_idle(input string name, input int maxc);
        bit ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            req = req & ~gnt_o;
            if (req == 0 && !busy_o && aq.size() == 0 && gq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_drain: got pending=%0d required 0 within %0d cycles", name, aq.size(), maxc);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt_o, ack_o, d_o, err_o, busy_o, core_go_o, core_x_o, core_y_o, core_rst_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got gnt=%b ack=%b d=%0d busy=%b go=%b required all 0",
                     gnt_o, ack_o, d_o, busy_o, core_go_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int kc;
        core_lat = 5;
        set_ops(2, 4'd12, 4'd8);
        expect_txn(2, 4'd4, 1'b0);
        req = 4'b0100;
        @(posedge clk); t0 = $time;
        @(negedge clk);
        checks++;
        if ({core_go_o, core_x_o, core_y_o} !== {1'b1, 4'd12, 4'd8}) begin
            failures++;
            $display("FAIL single_issue: got go=%b x=%0d y=%0d required go=1 x=12 y=8", core_go_o, core_x_o, core_y_o);
        end
        req = '0;
        wait_ack(20, kc);
        checks++;
        if (kc !== 7) begin failures++; $display("FAIL single_latency: got cycle %0d required 7", kc); end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL single_busy: got %b required 0", busy_o); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] xs[N] = '{4'd6, 4'd15, 4'd9, 4'd14};
        logic [W-1:0] ys[N] = '{4'd4, 4'd10, 4'd12, 4'd7};
        do_reset();
        core_lat = 2;
        for (int k = 0; k < N; k++) begin
            set_ops(k, xs[k], ys[k]);
            expect_txn(k, gcd_ref(xs[k], ys[k]), 1'b0);
        end
        req = '1;
        run_until_idle("round_robin", 100);
    endtask

    task automatic test_ptr();
        do_reset();
        core_lat = 1;
        set_ops(1, 4'd8, 4'd12);
        set_ops(0, 4'd10, 4'd4);
        expect_txn(1, 4'd4, 1'b0);
        req = 4'b0010;
        run_until_idle("ptr_first", 20);
        expect_txn(0, 4'd2, 1'b0);
        expect_txn(1, 4'd4, 1'b0);
        req = 4'b0011;
        run_until_idle("ptr_pair", 40);
    endtask

    task automatic test_zero();
        int kc, g0;
        logic [W-1:0] xs[3] = '{4'd0, 4'd0, 4'd5};
        logic [W-1:0] ys[3] = '{4'd9, 4'd0, 4'd0};
        int           sl[3] = '{3, 0, 1};
        logic [W-1:0] dv[3] = '{4'd9, 4'd0, 4'd5};
        for (int t = 0; t < 3; t++) begin
            g0 = go_cnt;
            set_ops(sl[t], xs[t], ys[t]);
            expect_txn(sl[t], dv[t], 1'b0);
            req = '0; req[sl[t]] = 1'b1;
            @(posedge clk); t0 = $time;
            @(negedge clk); req = '0;
            wait_ack(10, kc);
            checks++;
            if (kc !== 2) begin failures++; $display("FAIL zero_latency_%0d: got cycle %0d required 2", t, kc); end
            @(negedge clk);
            checks++;
            if (go_cnt !== g0) begin failures++; $display("FAIL zero_no_go_%0d: got %0d go pulses required 0", t, go_cnt - g0); end
        end
    endtask

    task automatic test_timeout();
        int kc;
        core_hang = 1'b1;
        set_ops(2, 4'd6, 4'd9);
        expect_txn(2, 4'd0, 1'b1);
        req = 4'b0100;
        @(posedge clk); t0 = $time;
        @(negedge clk); req = '0;
        wait_ack(100, kc);
        checks++;
        if (kc !== TO + 2) begin failures++; $display("FAIL timeout_latency: got cycle %0d required %0d", kc, TO + 2); end
        @(negedge clk);
        core_hang = 1'b0;
        core_lat  = 1;
        set_ops(3, 4'd6, 4'd9);
        expect_txn(3, 4'd3, 1'b0);
        req = 4'b1000;
        @(posedge clk); t0 = $time;
        @(negedge clk); req = '0;
        wait_ack(20, kc);
        checks++;
        if (kc !== 3) begin failures++; $display("FAIL after_abort_latency: got cycle %0d required 3", kc); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        core_lat = 10;
        set_ops(0, 4'd10, 4'd15);
        expect_txn(0, 4'd5, 1'b0);
        req = 4'b0001;
        @(posedge clk);
        @(negedge clk); req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt_o, ack_o, d_o, err_o, busy_o, core_go_o, core_x_o, core_y_o, core_rst_o} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got busy=%b d=%0d x=%0d crst=%b required all 0", busy_o, d_o, core_x_o, core_rst_o);
        end
        gq.delete();
        aq.delete();
        @(negedge clk); rst = 1'b0;
        done_force = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ack_o != 0) acks++;
        end
        done_force = 1'b0;
        checks++;
        if (acks !== 0) begin failures++; $display("FAIL stale_done: got %0d acks required 0", acks); end
        core_lat = 1;
        set_ops(3, 4'd12, 4'd9);
        expect_txn(0, 4'd5, 1'b0);
        expect_txn(3, 4'd3, 1'b0);
        req = 4'b1001;
        run_until_idle("after_midreset", 40);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ptr();
        test_zero();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion required finish");
        $fatal(1, "bench time limit");
    end

endmodule
